// File: rtl/lspc_clkdiv_gen.sv
// Clock-enable generator: binary divider chain with per-stage enables plus a
// programmable integer divider with a half-rate output, driven from EN_P/EN_N.
module lspc_clkdiv_gen #(
  parameter int STAGES      = 4,
  parameter int RESET_PHASE = 2,
  parameter int ODIV_W      = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN_P,
  input  logic              EN_N,
  input  logic              HOLD,
  input  logic              RESYNC,
  input  logic [ODIV_W-1:0] ODIV,
  output logic [STAGES-1:0] DIV_CNT,
  output logic              CARRY,
  output logic [STAGES-1:0] BEN_P,
  output logic [STAGES-1:0] BEN_N,
  output logic              OCLK,
  output logic              OHALF,
  output logic              OEN_P,
  output logic              OEN_N
);

  localparam logic [STAGES-1:0] PHASE   = STAGES'(RESET_PHASE);
  localparam logic [STAGES-1:0] CNT_ONE = STAGES'(1);
  localparam logic [ODIV_W-1:0] O_ONE   = ODIV_W'(1);
  localparam logic [ODIV_W-1:0] O_TWO   = ODIV_W'(2);

  logic              resync_pend;
  logic [ODIV_W-1:0] ocnt;
  logic [ODIV_W-1:0] ratio;
  logic [ODIV_W-1:0] ratio_last;
  logic [ODIV_W-1:0] odiv_eff;
  logic              en_p_ok;
  logic              en_n_ok;
  logic              ocnt_last;
  logic              ofall;
  logic              orise;
  logic [STAGES-1:0] ben_p_nxt;
  logic [STAGES-1:0] ben_n_nxt;

  function automatic logic [STAGES-1:0] stage_mask(input int k);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      m[i] = (i <= k);
    end
    return m;
  endfunction

  // Reset also gates the enables so a reset cycle never emits a pulse.
  always_comb begin
    en_p_ok    = EN_P && !HOLD && !RESET;
    en_n_ok    = EN_N && !HOLD && !RESET;
    odiv_eff   = (ODIV < O_TWO) ? O_TWO : ODIV;
    ratio_last = ratio - O_ONE;
    ocnt_last  = (ocnt == ratio_last);
    ofall      = en_p_ok && ocnt_last;
    orise      = en_n_ok && (ocnt == '0);
  end

  always_comb begin
    ben_p_nxt = '0;
    ben_n_nxt = '0;
    for (int k = 0; k < STAGES; k++) begin
      ben_p_nxt[k] = en_p_ok && ((DIV_CNT & stage_mask(k)) == (stage_mask(k) >> 1));
      ben_n_nxt[k] = en_p_ok && ((DIV_CNT & stage_mask(k)) == stage_mask(k));
    end
  end

  // A RESYNC arriving in the same cycle as a consuming EN_N re-arms the flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DIV_CNT     <= PHASE;
      resync_pend <= 1'b0;
    end else begin
      if (en_n_ok) begin
        if (resync_pend) begin
          DIV_CNT     <= PHASE;
          resync_pend <= 1'b0;
        end else begin
          DIV_CNT <= DIV_CNT + CNT_ONE;
        end
      end
      if (RESYNC) begin
        resync_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BEN_P <= '0;
      BEN_N <= '0;
    end else begin
      BEN_P <= ben_p_nxt;
      BEN_N <= ben_n_nxt;
    end
  end

  // The ratio is only relatched on wrap, so a new ODIV never shortens a period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ocnt  <= '0;
      ratio <= odiv_eff;
      OCLK  <= 1'b1;
      OHALF <= 1'b0;
    end else begin
      if (en_n_ok) begin
        if (ocnt_last) begin
          ocnt  <= '0;
          ratio <= odiv_eff;
        end else begin
          ocnt <= ocnt + O_ONE;
        end
      end
      if (ofall) begin
        OCLK <= 1'b0;
      end else if (orise) begin
        OCLK <= 1'b1;
      end
      if (ofall) begin
        OHALF <= ~OHALF;
      end
    end
  end

  assign CARRY = &DIV_CNT;
  assign OEN_P = ofall && !OHALF;
  assign OEN_N = ofall && OHALF;

endmodule

// File: tb/tb_lspc_clkdiv_gen.sv
// Self-checking bench for lspc_clkdiv_gen: a per-cycle reference model feeds a
// scoreboard queue, plus scenario tasks with targeted checks.
module tb_lspc_clkdiv_gen;

  localparam int STAGES = 4;
  localparam int RP     = 2;
  localparam int OW     = 3;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              EN_P = 1'b0;
  logic              EN_N = 1'b0;
  logic              HOLD = 1'b0;
  logic              RESYNC = 1'b0;
  logic [OW-1:0]     ODIV = 3'd3;
  logic [STAGES-1:0] DIV_CNT;
  logic              CARRY;
  logic [STAGES-1:0] BEN_P;
  logic [STAGES-1:0] BEN_N;
  logic              OCLK;
  logic              OHALF;
  logic              OEN_P;
  logic              OEN_N;

  int total = 0;
  int bad   = 0;

  int               m_cnt;
  int               m_ocnt;
  int               m_r;
  bit               m_pend;
  bit               m_oclk;
  bit               m_ohalf;
  bit               m_valid = 0;
  logic [STAGES-1:0] m_benp;
  logic [STAGES-1:0] m_benn;
  logic [13:0]      exp_q[$];
  logic             last_oenp;
  logic             last_oenn;

  lspc_clkdiv_gen #(.STAGES(STAGES), .RESET_PHASE(RP), .ODIV_W(OW)) dut (
    .CLK(CLK), .RESET(RESET), .EN_P(EN_P), .EN_N(EN_N), .HOLD(HOLD),
    .RESYNC(RESYNC), .ODIV(ODIV), .DIV_CNT(DIV_CNT), .CARRY(CARRY),
    .BEN_P(BEN_P), .BEN_N(BEN_N), .OCLK(OCLK), .OHALF(OHALF),
    .OEN_P(OEN_P), .OEN_N(OEN_N)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One CLK: drive inputs, check combinational outputs, advance the model,
  // queue the expected registered outputs and compare after the edge.
  task automatic tick(input bit p, input bit n, input bit rs, input bit rst);
    logic [13:0] e;
    logic [2:0]  ec;
    bit ep, en, fall, rise;
    int r_eff;
    EN_P = p; EN_N = n; RESYNC = rs; RESET = rst;
    #1;
    ep   = p && !HOLD && !rst;
    en   = n && !HOLD && !rst;
    fall = ep && (m_ocnt == m_r - 1);
    rise = en && (m_ocnt == 0);
    ec   = {m_cnt == 15, fall && !m_ohalf, fall && m_ohalf};
    if (m_valid) begin
      total++;
      if ({CARRY, OEN_P, OEN_N} !== ec) begin
        bad++;
        $display("[TB] FAIL comb {CARRY,OEN_P,OEN_N}: got %b expected %b (t=%0t)",
                 {CARRY, OEN_P, OEN_N}, ec, $time);
      end
    end
    last_oenp = OEN_P;
    last_oenn = OEN_N;
    r_eff = (int'(ODIV) < 2) ? 2 : int'(ODIV);
    if (rst) begin
      m_cnt = RP; m_pend = 0; m_ocnt = 0; m_r = r_eff;
      m_oclk = 1; m_ohalf = 0; m_benp = '0; m_benn = '0; m_valid = 1;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        m_benp[k] = ep && ((m_cnt % (2 ** (k + 1))) == (2 ** k) - 1);
        m_benn[k] = ep && ((m_cnt % (2 ** (k + 1))) == (2 ** (k + 1)) - 1);
      end
      if (en) begin
        if (m_pend) begin
          m_cnt = RP; m_pend = 0;
        end else begin
          m_cnt = (m_cnt + 1) % 16;
        end
        if (m_ocnt == m_r - 1) begin
          m_ocnt = 0; m_r = r_eff;
        end else begin
          m_ocnt = m_ocnt + 1;
        end
      end
      if (rs) m_pend = 1;
      if (fall) m_oclk = 0;
      else if (rise) m_oclk = 1;
      if (fall) m_ohalf = !m_ohalf;
    end
    if (m_valid) exp_q.push_back({4'(m_cnt), m_benp, m_benn, m_oclk, m_ohalf});
    @(posedge CLK);
    #1;
    if (m_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = exp_q.pop_front();
        if ({DIV_CNT, BEN_P, BEN_N, OCLK, OHALF} !== e) begin
          bad++;
          $display("[TB] FAIL regs {DIV_CNT,BEN_P,BEN_N,OCLK,OHALF}: got %h/%b/%b/%b/%b expected %h/%b/%b/%b/%b (t=%0t)",
                   DIV_CNT, BEN_P, BEN_N, OCLK, OHALF,
                   e[13:10], e[9:6], e[5:2], e[1], e[0], $time);
        end
      end
    end
  endtask

  task automatic master(output logic [3:0] bp, output logic [3:0] bn,
                        output logic op, output logic on);
    tick(1, 0, 0, 0);
    bp = BEN_P; bn = BEN_N; op = last_oenp; on = last_oenn;
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    ODIV = 3'd3;
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    total++;
    if (DIV_CNT !== 4'd2) begin
      bad++; $display("[TB] FAIL reset_div_cnt: got %0d expected 2", DIV_CNT);
    end
    total++;
    if ({BEN_P, BEN_N} !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_ben: got %b expected 00000000", {BEN_P, BEN_N});
    end
    total++;
    if ({OCLK, OHALF} !== 2'b10) begin
      bad++; $display("[TB] FAIL reset_oclk_ohalf: got %b expected 10", {OCLK, OHALF});
    end
  endtask

  task automatic test_count();
    logic [3:0] bp, bn;
    logic op, on;
    logic [3:0] pre;
    int nbp = 0, nbn = 0;
    logic [3:0] bp_at = '0, bn_at = '0;
    for (int i = 1; i <= 16; i++) begin
      pre = DIV_CNT;
      master(bp, bn, op, on);
      if (bp[3]) begin nbp++; bp_at = pre; end
      if (bn[3]) begin nbn++; bn_at = pre; end
      total++;
      if (DIV_CNT !== 4'((2 + i) % 16)) begin
        bad++; $display("[TB] FAIL count_seq[%0d]: got %0d expected %0d", i, DIV_CNT, (2 + i) % 16);
      end
    end
    total++;
    if (nbp != 1 || bp_at !== 4'd7) begin
      bad++; $display("[TB] FAIL ben_p3: got %0d pulses at %0d expected 1 at 7", nbp, bp_at);
    end
    total++;
    if (nbn != 1 || bn_at !== 4'd15) begin
      bad++; $display("[TB] FAIL ben_n3: got %0d pulses at %0d expected 1 at 15", nbn, bn_at);
    end
  endtask

  task automatic test_odiv();
    logic [3:0] bp, bn;
    logic op, on;
    int nop = 0, non = 0, alt_err = 0, first = 0;
    logic prev_p = 1'b0;
    ODIV = 3'd3;
    tick(0, 0, 0, 1);
    for (int i = 1; i <= 12; i++) begin
      master(bp, bn, op, on);
      if (op || on) begin
        if (first == 0) first = i;
        if ((op && prev_p) || (on && !prev_p) || (op && on)) alt_err++;
        prev_p = op;
        if (op) nop++;
        if (on) non++;
      end
    end
    total++;
    if (nop != 2 || non != 2 || alt_err != 0) begin
      bad++; $display("[TB] FAIL odiv3_oen: got p=%0d n=%0d alt_err=%0d expected p=2 n=2 alt_err=0", nop, non, alt_err);
    end
    total++;
    if (first != 3) begin
      bad++; $display("[TB] FAIL odiv3_first_fall: got master %0d expected 3", first);
    end
  endtask

  task automatic test_ratio_change();
    logic [3:0] bp, bn;
    logic op, on;
    int fl[$];
    ODIV = 3'd5;
    for (int j = 1; j <= 14; j++) begin
      master(bp, bn, op, on);
      if (op || on) fl.push_back(j);
    end
    total++;
    if (fl.size() != 3 || fl[0] != 3 || fl[1] != 8 || fl[2] != 13) begin
      bad++; $display("[TB] FAIL ratio_change_falls: got %p expected '{3, 8, 13}", fl);
    end
  endtask

  task automatic test_hold();
    logic [3:0] bp, bn;
    logic op, on;
    int tries = 0;
    logic any = 1'b0;
    while (DIV_CNT !== 4'd9 && tries < 20) begin
      master(bp, bn, op, on);
      tries++;
    end
    total++;
    if (DIV_CNT !== 4'd9) begin
      bad++; $display("[TB] FAIL hold_reach9: got %0d expected 9", DIV_CNT);
    end
    HOLD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      master(bp, bn, op, on);
      any = any | (|bp) | (|bn) | op | on;
    end
    total++;
    if (DIV_CNT !== 4'd9 || any !== 1'b0) begin
      bad++; $display("[TB] FAIL hold_freeze: got cnt=%0d pulses=%b expected cnt=9 pulses=0", DIV_CNT, any);
    end
    HOLD = 1'b0;
    master(bp, bn, op, on);
    total++;
    if (DIV_CNT !== 4'd10) begin
      bad++; $display("[TB] FAIL hold_resume: got %0d expected 10", DIV_CNT);
    end
  endtask

  task automatic test_resync();
    logic [3:0] bp, bn;
    logic op, on;
    int tries = 0;
    while (DIV_CNT !== 4'd12 && tries < 20) begin
      master(bp, bn, op, on);
      tries++;
    end
    tick(0, 0, 1, 0);
    master(bp, bn, op, on);
    total++;
    if (DIV_CNT !== 4'd2) begin
      bad++; $display("[TB] FAIL resync_load: got %0d expected 2", DIV_CNT);
    end
    master(bp, bn, op, on);
    total++;
    if (DIV_CNT !== 4'd3) begin
      bad++; $display("[TB] FAIL resync_consumed: got %0d expected 3", DIV_CNT);
    end
    master(bp, bn, op, on);
    tick(0, 0, 1, 1);
    total++;
    if (DIV_CNT !== 4'd2) begin
      bad++; $display("[TB] FAIL reset_resync_cnt: got %0d expected 2", DIV_CNT);
    end
    master(bp, bn, op, on);
    total++;
    if (DIV_CNT !== 4'd3) begin
      bad++; $display("[TB] FAIL reset_resync_pend: got %0d expected 3", DIV_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] start;
    start = DIV_CNT;
    for (int i = 0; i < 6; i++) begin
      tick(1, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    total++;
    if (DIV_CNT !== 4'((int'(start) + 6) % 16)) begin
      bad++; $display("[TB] FAIL simultaneous_count: got %0d expected %0d", DIV_CNT, (int'(start) + 6) % 16);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bp, bn;
    logic op, on;
    for (int i = 0; i < 5; i++) master(bp, bn, op, on);
    tick(1, 1, 0, 1);
    total++;
    if ({last_oenp, last_oenn} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_mid_oen: got %b expected 00", {last_oenp, last_oenn});
    end
    total++;
    if ({DIV_CNT, BEN_P, BEN_N, OCLK, OHALF} !== {4'd2, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL reset_mid_state: got %h/%b/%b/%b/%b expected 2/0000/0000/1/0",
                      DIV_CNT, BEN_P, BEN_N, OCLK, OHALF);
    end
  endtask

  task automatic test_odiv_low();
    logic [3:0] bp, bn;
    logic op, on;
    int n = 0;
    ODIV = 3'd0;
    tick(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      master(bp, bn, op, on);
      if (op || on) n++;
    end
    total++;
    if (n != 3) begin
      bad++; $display("[TB] FAIL odiv0_as_2: got %0d falls expected 3", n);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_count();
    test_odiv();
    test_ratio_change();
    test_hold();
    test_resync();
    test_back_to_back();
    test_reset_mid();
    test_odiv_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
